// File: rtl/rgbw_pwm_scheduler_if.sv
// Host-side duty staging and commit handshake for rgbw_pwm_scheduler.
interface rgbw_pwm_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             wr_valid;
  logic [1:0]       wr_ch;
  logic [CNT_W-1:0] wr_duty;
  logic             wr_ready;
  logic             commit;
  logic             commit_pending;

  modport master (
    output wr_valid, wr_ch, wr_duty, commit,
    input  wr_ready, commit_pending
  );

  modport slave (
    input  wr_valid, wr_ch, wr_duty, commit,
    output wr_ready, commit_pending
  );
endinterface

// File: rtl/rgbw_pwm_scheduler.sv
// Four-channel RGBW PWM sequencer: shadowed duties are committed atomically at the period wrap,
// with optional quarter-period phase staggering between channels.
module rgbw_pwm_scheduler #(
  parameter int CNT_W   = 8,
  parameter int STAGGER = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                presc_in,
  input  logic                enable,
  rgbw_pwm_scheduler_if.slave bus,
  output logic                period_start,
  output logic [3:0]          pwm
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] PH_STEP = (STAGGER != 0) ? (CNT_ONE << (CNT_W - 2)) : {CNT_W{1'b0}};

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_presc_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_shadow [4];
  logic [CNT_W-1:0] r_active [4];
  logic             r_period_start;
  logic [3:0]       r_pwm;

  logic             w_tick;
  logic             w_wrap;
  logic             w_pending;
  logic             w_apply;
  logic             w_wr_acc;
  logic [CNT_W-1:0] w_phase [4];
  logic [3:0]       w_pwm_nxt;

  assign w_pending = (r_state == ST_PENDING);
  assign w_tick    = presc_in & ~r_presc_d & enable;
  assign w_wrap    = w_tick & (r_cnt == CNT_MAX);
  assign w_wr_acc  = bus.wr_valid & ~w_pending;

  assign bus.wr_ready       = ~w_pending;
  assign bus.commit_pending = w_pending;
  assign period_start       = r_period_start;
  assign pwm                = r_pwm;

  // Per-channel phase and compare; the offset is zero for every channel when staggering is off.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_phase[i]   = r_cnt + (PH_STEP * CNT_W'(i));
      w_pwm_nxt[i] = enable & (w_phase[i] < r_active[i]);
    end
  end

  // Commit FSM: a pending commit lands on the wrap, or immediately while disabled.
  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.commit) begin
          w_state_nxt = ST_PENDING;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (w_wrap | ~enable) begin
          w_state_nxt = ST_IDLE;
          w_apply     = 1'b1;
        end else begin
          w_state_nxt = ST_PENDING;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_apply     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Tick detection, period counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc_d      <= 1'b0;
      r_cnt          <= {CNT_W{1'b0}};
      r_period_start <= 1'b0;
      r_pwm          <= 4'b0000;
    end else begin
      r_presc_d      <= presc_in;
      r_period_start <= w_wrap;
      r_pwm          <= w_pwm_nxt;
      if (!enable) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (w_tick) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Shadow staging and atomic transfer; writes and applies never coincide because both key off pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= {CNT_W{1'b0}};
        r_active[i] <= {CNT_W{1'b0}};
      end
    end else begin
      if (w_apply) begin
        for (int i = 0; i < 4; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (w_wr_acc) begin
        r_shadow[bus.wr_ch] <= bus.wr_duty;
      end
    end
  end

endmodule

// File: tb/tb_rgbw_pwm_scheduler.sv
// Scoreboard bench: a tick-level reference model predicts every clk's outputs for an unstaggered
// and a staggered instance; a monitor compares them on the falling edge.
module tb_rgbw_pwm_scheduler;
  localparam int CNT_W = 8;
  localparam int P     = 1 << CNT_W;
  localparam int Q     = P / 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             presc_in;
  logic             enable;
  logic             wr_valid;
  logic [1:0]       wr_ch;
  logic [CNT_W-1:0] wr_duty;
  logic             commit;
  logic             ps0, ps1;
  logic [3:0]       pwm0, pwm1;

  rgbw_pwm_scheduler_if #(.CNT_W(CNT_W)) bus0 ();
  rgbw_pwm_scheduler_if #(.CNT_W(CNT_W)) bus1 ();

  assign bus0.wr_valid = wr_valid;
  assign bus0.wr_ch    = wr_ch;
  assign bus0.wr_duty  = wr_duty;
  assign bus0.commit   = commit;
  assign bus1.wr_valid = wr_valid;
  assign bus1.wr_ch    = wr_ch;
  assign bus1.wr_duty  = wr_duty;
  assign bus1.commit   = commit;

  rgbw_pwm_scheduler #(.CNT_W(CNT_W), .STAGGER(0)) u_dut0 (
    .clk(clk), .reset(reset), .presc_in(presc_in), .enable(enable),
    .bus(bus0), .period_start(ps0), .pwm(pwm0)
  );

  rgbw_pwm_scheduler #(.CNT_W(CNT_W), .STAGGER(1)) u_dut1 (
    .clk(clk), .reset(reset), .presc_in(presc_in), .enable(enable),
    .bus(bus1), .period_start(ps1), .pwm(pwm1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pwm0;
    logic [3:0] pwm1;
    logic       ps;
    logic       rdy;
    logic       pend;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // reference model state
  int m_cnt;
  bit m_presc_d;
  int m_shadow[4];
  int m_active[4];
  bit m_pending;
  bit m_wr_acc;
  int hp;
  int hcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    m_presc_d = 1'b0;
    m_pending = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
  endtask

  // Predict the outputs that follow this clock edge from the inputs seen at it.
  task automatic model_step();
    exp_t e;
    bit   tick, wrap, old_pend;
    m_wr_acc = 1'b0;
    e.pwm0 = 4'b0000;
    e.pwm1 = 4'b0000;
    if (!reset) begin
      model_reset();
      e.ps   = 1'b0;
      e.rdy  = 1'b1;
      e.pend = 1'b0;
    end else begin
      old_pend = m_pending;
      tick = presc_in && !m_presc_d && enable;
      wrap = tick && (m_cnt == P - 1);
      for (int i = 0; i < 4; i++) begin
        if (enable && (m_cnt < m_active[i]))                 e.pwm0[i] = 1'b1;
        if (enable && (((m_cnt + i * Q) % P) < m_active[i])) e.pwm1[i] = 1'b1;
      end
      e.ps = wrap;
      if (old_pend && (wrap || !enable)) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end else if (commit && !old_pend) begin
        m_pending = 1'b1;
      end
      if (wr_valid && !old_pend) begin
        m_shadow[wr_ch] = int'(wr_duty);
        m_wr_acc = 1'b1;
      end
      if (!enable)   m_cnt = 0;
      else if (tick) m_cnt = (m_cnt + 1) % P;
      m_presc_d = presc_in;
      e.rdy  = !m_pending;
      e.pend = m_pending;
    end
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    hcnt++;
    if (hcnt >= hp) begin
      hcnt     = 0;
      presc_in = ~presc_in;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_write(input int ch, input int duty);
    wr_valid = 1'b1;
    wr_ch    = 2'(ch);
    wr_duty  = CNT_W'(duty);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic check_async_reset(input string tag);
    chk({tag, "_pwm0"}, pwm0, 0);
    chk({tag, "_pwm1"}, pwm1, 0);
    chk({tag, "_ps0"}, ps0, 0);
    chk({tag, "_ps1"}, ps1, 0);
    chk({tag, "_rdy0"}, bus0.wr_ready, 1);
    chk({tag, "_rdy1"}, bus1.wr_ready, 1);
    chk({tag, "_pend0"}, bus0.commit_pending, 0);
    chk({tag, "_pend1"}, bus1.commit_pending, 0);
  endtask

  task automatic random_run(input int n);
    int dis = 0;
    for (int k = 0; k < n; k++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_ch    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       wr_duty = CNT_W'(0);
        1:       wr_duty = CNT_W'(P - 1);
        default: wr_duty = CNT_W'($urandom_range(0, P - 1));
      endcase
      commit = ($urandom_range(0, 59) == 0);
      if (dis > 0) begin
        dis--;
        enable = (dis == 0);
      end else if ($urandom_range(0, 799) == 0) begin
        dis    = $urandom_range(1, 8);
        enable = 1'b0;
      end
      step();
    end
    wr_valid = 1'b0;
    commit   = 1'b0;
    enable   = 1'b1;
  endtask

  // Monitor: pops one prediction per clk and compares away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("pwm_nostagger", pwm0, mon_e.pwm0);
        chk("pwm_stagger", pwm1, mon_e.pwm1);
        chk("period_start0", ps0, mon_e.ps);
        chk("period_start1", ps1, mon_e.ps);
        chk("wr_ready0", bus0.wr_ready, mon_e.rdy);
        chk("wr_ready1", bus1.wr_ready, mon_e.rdy);
        chk("commit_pending0", bus0.commit_pending, mon_e.pend);
        chk("commit_pending1", bus1.commit_pending, mon_e.pend);
      end
    end
  end

  initial begin
    bit hit;
    reset    = 1'b0;
    presc_in = 1'b0;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_ch    = 2'd0;
    wr_duty  = {CNT_W{1'b0}};
    commit   = 1'b0;
    hp       = 2;
    hcnt     = 0;
    model_reset();
    #1;
    check_async_reset("por");
    run(3);
    reset  = 1'b1;
    enable = 1'b1;

    // idle: no duties, period_start every 256 ticks
    run(2200);

    // unequal duties including the 0 and full-scale extremes
    hp = 1;
    do_write(0, 64);
    do_write(1, 128);
    do_write(2, 0);
    do_write(3, 255);
    do_commit();
    run(1100);

    // equal duties exercise the stagger offsets
    for (int c = 0; c < 4; c++) do_write(c, 64);
    do_commit();
    run(1100);

    // write held while a commit is pending
    do_commit();
    wr_valid = 1'b1;
    wr_ch    = 2'd1;
    wr_duty  = CNT_W'(200);
    hit      = 1'b0;
    for (int k = 0; k < 1200 && !hit; k++) begin
      step();
      hit = m_wr_acc;
    end
    wr_valid = 1'b0;
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL held_write_timeout: got not accepted expected accepted at %0t", $time);
    end
    run(600);
    do_commit();
    run(1100);

    // commit on the wrap edge itself
    do_write(0, 10);
    hit = 1'b0;
    for (int k = 0; k < 1200 && !hit; k++) begin
      if (presc_in && !m_presc_d && enable && (m_cnt == P - 1)) begin
        do_commit();
        hit = 1'b1;
      end else begin
        step();
      end
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wrap_commit_timeout: got no wrap expected wrap at %0t", $time);
    end
    run(1100);

    // disable with a pending commit, then re-enable
    do_write(2, 180);
    do_write(3, 30);
    do_commit();
    run(20);
    enable = 1'b0;
    run(5);
    enable = 1'b1;
    run(1100);

    hp = 1;
    random_run(6000);
    hp = 2;
    random_run(3000);

    // reset mid-period with a pending commit
    do_write(1, 99);
    do_commit();
    run(10);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_async_reset("mid_reset");
    run(3);
    reset = 1'b1;
    hp = 1;
    random_run(1500);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
